// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the CPU front end.
//   - RESET_PC  : PC value the core starts from; also the idle value of an
//                 unused fetch slot's PC field.
//   - INSTR_W   : instruction word width.
//   - NOP_INSTR : canonical NOP (addi x0, x0, 0); idle value of a slot's
//                 instruction field so an empty head never looks like a
//                 meaningful instruction.
//   - fetch_entry_t : one fetch slot {pc, instr, filled}.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_slot_buf.sv
// -----------------------------------------------------------------------------
// fetch_slot_buf
//   DEPTH-entry storage for in-order instruction fetches. Each slot holds the
//   PC it was allocated for, the returned instruction word and a filled flag.
//   Pointer bookkeeping lives in the parent; this block only stores.
//
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     clr           invalidate every slot (redirect); wins over all writes
//     alloc_en/idx/pc   allocate slot idx for a newly accepted fetch of pc
//     fill_en/idx/instr write the returned instruction word into slot idx
//     pop_en        release the slot at rd_idx (consumed by decode)
//     rd_idx        head slot index
//     rd_entry      combinational read of the head slot
// -----------------------------------------------------------------------------
module fetch_slot_buf
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               alloc_en,
  input  logic [PTR_W-1:0]   alloc_idx,
  input  logic [31:0]        alloc_pc,
  input  logic               fill_en,
  input  logic [PTR_W-1:0]   fill_idx,
  input  logic [INSTR_W-1:0] fill_instr,
  input  logic               pop_en,
  input  logic [PTR_W-1:0]   rd_idx,
  output fetch_entry_t       rd_entry
);

  fetch_entry_t slot_arr [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      fetch_entry_t entry_reg;

      // The parent guarantees that alloc, fill and pop never target the same
      // slot in one cycle (alloc hits an unallocated slot, fill an allocated
      // unfilled one, pop a filled one), so the write order below is moot.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg.pc     <= RESET_PC;
          entry_reg.instr  <= NOP_INSTR;
          entry_reg.filled <= 1'b0;
        end else if (clr) begin
          entry_reg.filled <= 1'b0;
        end else begin
          if (alloc_en && (alloc_idx == PTR_W'(gi))) begin
            entry_reg.pc     <= alloc_pc;
            entry_reg.filled <= 1'b0;
          end
          if (fill_en && (fill_idx == PTR_W'(gi))) begin
            entry_reg.instr  <= fill_instr;
            entry_reg.filled <= 1'b1;
          end
          if (pop_en && (rd_idx == PTR_W'(gi))) begin
            entry_reg.filled <= 1'b0;
          end
        end
      end

      assign slot_arr[gi] = entry_reg;
    end
  endgenerate

  assign rd_entry = slot_arr[rd_idx];

endmodule

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//   Instruction-fetch front end between the PC register and decode.
//   Issues in-order fetches at pc_i, holds the PC until a fetch for it is
//   accepted, buffers returned words tagged with their PC and presents them to
//   decode with a valid/ready handshake. A redirect (flush_i) empties the
//   buffer and arranges for responses to fetches still in flight to be
//   discarded as they come back.
//
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     pc_i                current PC from the PC register
//     pc_hold_o           1 = PC register keeps its value
//     flush_i             redirect; PC register loads the target this cycle
//     imem_req_valid_o    fetch request valid
//     imem_req_addr_o     fetch address (= pc_i)
//     imem_req_ready_i    memory accepts the request
//     imem_rsp_valid_i    response valid, in request order, latency >= 1
//     imem_rsp_data_i     returned instruction word
//     id_valid_o          head instruction available to decode
//     id_pc_o, id_instr_o head PC and instruction word
//     id_ready_i          decode consumes the head this cycle
//     err_o               sticky: a response arrived with nothing pending
// -----------------------------------------------------------------------------
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc_i,
  output logic               pc_hold_o,
  input  logic               flush_i,
  output logic               imem_req_valid_o,
  output logic [31:0]        imem_req_addr_o,
  input  logic               imem_req_ready_i,
  input  logic               imem_rsp_valid_i,
  input  logic [INSTR_W-1:0] imem_rsp_data_i,
  output logic               id_valid_o,
  output logic [31:0]        id_pc_o,
  output logic [INSTR_W-1:0] id_instr_o,
  input  logic               id_ready_i,
  output logic               err_o
);

  // Pointers: head = next slot to hand to decode, fill = next slot awaiting
  // its response, tail = next slot to allocate.
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] fill_reg, fill_next;
  logic [PTR_W-1:0] tail_reg, tail_next;

  // occ  = allocated slots (filled or not)
  // pend = allocated slots still waiting for their response
  // drop = responses to fetches abandoned by a redirect, still to come back
  logic [CNT_W-1:0] occ_reg,  occ_next;
  logic [CNT_W-1:0] pend_reg, pend_next;
  logic [CNT_W-1:0] drop_reg, drop_next;
  logic             err_reg,  err_next;

  logic [CNT_W-1:0] used_sum;
  logic [CNT_W-1:0] backlog;
  logic             has_room;
  logic             accept;
  logic             pop;
  logic             rsp_drop;
  logic             rsp_fill;
  logic             rsp_spur;
  fetch_entry_t     head_entry;

  // ---------------------------------------------------------------------------
  // Slot storage
  // ---------------------------------------------------------------------------
  fetch_slot_buf #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_slot_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush_i),
    .alloc_en   (accept),
    .alloc_idx  (tail_reg),
    .alloc_pc   (pc_i),
    .fill_en    (rsp_fill && !flush_i),
    .fill_idx   (fill_reg),
    .fill_instr (imem_rsp_data_i),
    .pop_en     (pop),
    .rd_idx     (head_reg),
    .rd_entry   (head_entry)
  );

  // ---------------------------------------------------------------------------
  // Issue / handshake
  // ---------------------------------------------------------------------------
  // occ + drop never exceeds DEPTH, which fits in CNT_W bits.
  assign used_sum = occ_reg + drop_reg;

  // A pop in the same cycle is deliberately not credited: keeps the request
  // path independent of id_ready_i.
  assign has_room = (used_sum < CNT_W'(DEPTH));

  assign imem_req_valid_o = !rst && !flush_i && has_room;
  assign imem_req_addr_o  = pc_i;
  assign accept           = imem_req_valid_o && imem_req_ready_i;

  // On a redirect the hold is released so the PC register takes the target.
  assign pc_hold_o = rst || (!accept && !flush_i);

  assign id_valid_o = !rst && head_entry.filled;
  assign id_pc_o    = head_entry.pc;
  assign id_instr_o = head_entry.instr;
  assign pop        = id_valid_o && id_ready_i && !flush_i;

  // Responses pay off abandoned fetches first, then fill in order; anything
  // beyond that has no matching request.
  assign rsp_drop = imem_rsp_valid_i && (drop_reg != '0);
  assign rsp_fill = imem_rsp_valid_i && (drop_reg == '0) && (pend_reg != '0);
  assign rsp_spur = imem_rsp_valid_i && (drop_reg == '0) && (pend_reg == '0);

  // Outstanding fetches at a redirect: earlier drops plus unfilled slots.
  assign backlog = drop_reg + pend_reg;

  assign err_o = err_reg;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    head_next = head_reg;
    fill_next = fill_reg;
    tail_next = tail_reg;
    occ_next  = occ_reg;
    pend_next = pend_reg;
    drop_next = drop_reg;
    err_next  = err_reg || rsp_spur;

    if (flush_i) begin
      head_next = '0;
      fill_next = '0;
      tail_next = '0;
      occ_next  = '0;
      pend_next = '0;
      // A response arriving in the redirect cycle belongs to the oldest
      // outstanding fetch, so it retires one of the abandoned requests.
      if (imem_rsp_valid_i && (backlog != '0)) begin
        drop_next = backlog - CNT_W'(1);
      end else begin
        drop_next = backlog;
      end
    end else begin
      if (accept)   tail_next = tail_reg + PTR_W'(1);
      if (pop)      head_next = head_reg + PTR_W'(1);
      if (rsp_fill) fill_next = fill_reg + PTR_W'(1);
      if (rsp_drop) drop_next = drop_reg - CNT_W'(1);

      case ({accept, pop})
        2'b10:   occ_next = occ_reg + CNT_W'(1);
        2'b01:   occ_next = occ_reg - CNT_W'(1);
        default: occ_next = occ_reg;
      endcase

      case ({accept, rsp_fill})
        2'b10:   pend_next = pend_reg + CNT_W'(1);
        2'b01:   pend_next = pend_reg - CNT_W'(1);
        default: pend_next = pend_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg <= '0;
      fill_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
      pend_reg <= '0;
      drop_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      head_reg <= head_next;
      fill_reg <= fill_next;
      tail_reg <= tail_next;
      occ_reg  <= occ_next;
      pend_reg <= pend_next;
      drop_reg <= drop_next;
      err_reg  <= err_next;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_queue
//   Directed bench for if_fetch_queue. The bench plays the PC register and the
//   instruction memory, and keeps a queue-based model of the fetch buffer.
//   Each cycle the DUT outputs are compared against the model at the falling
//   edge; a few hand-computed literal checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_if_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_hold_o;
  logic        flush_i;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_ready_i;
  logic        err_o;

  always #5 clk = ~clk;

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .pc_i             (pc_i),
    .pc_hold_o        (pc_hold_o),
    .flush_i          (flush_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .id_valid_o       (id_valid_o),
    .id_pc_o          (id_pc_o),
    .id_instr_o       (id_instr_o),
    .id_ready_i       (id_ready_i),
    .err_o            (err_o)
  );

  // Model: allocated fetches in order, oldest first.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_instr[$];
  bit          mq_filled[$];
  int          m_drop;
  bit          m_err;

  // Environment state.
  logic [31:0] inflight[$];
  bit          rsp_en;
  bit          spur_req;
  logic [31:0] flush_tgt;
  logic [31:0] pc_next;

  // Observation logs (one entry per compared cycle).
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  bit          hold_log[$];
  bit          vld_log[$];
  bit          err_log[$];
  int          acc_cnt;

  int cmp_cnt;
  int bad_cnt;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic bit exp_req_valid();
    return !rst && !flush_i && ((mq_pc.size() + m_drop) < DEPTH);
  endfunction

  function automatic bit exp_hold();
    if (rst) return 1'b1;
    return !(exp_req_valid() && imem_req_ready_i) && !flush_i;
  endfunction

  function automatic bit exp_id_valid();
    return !rst && (mq_pc.size() > 0) && mq_filled[0];
  endfunction

  task automatic check1(string name, logic act, logic exp);
    cmp_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_got(string name, int idx, logic [31:0] epc, logic [31:0] ein);
    cmp_cnt++;
    if (idx >= got_pc.size()) begin
      bad_cnt++;
      $display("FAIL %s: no delivery at position %0d, expected pc %h", name, idx, epc);
    end else if (got_pc[idx] !== epc || got_instr[idx] !== ein) begin
      bad_cnt++;
      $display("FAIL %s: got pc %h instr %h expected pc %h instr %h",
               name, got_pc[idx], got_instr[idx], epc, ein);
    end else begin
      $display("deliver %s: pc %h instr %h", name, got_pc[idx], got_instr[idx]);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare_cycle();
    bit ev_req;
    bit ev_id;
    ev_req = exp_req_valid();
    ev_id  = exp_id_valid();
    check1("imem_req_valid", imem_req_valid_o, ev_req);
    if (ev_req) check32("imem_req_addr", imem_req_addr_o, pc_i);
    check1("pc_hold", pc_hold_o, exp_hold());
    check1("id_valid", id_valid_o, ev_id);
    if (ev_id) begin
      check32("id_pc", id_pc_o, mq_pc[0]);
      check32("id_instr", id_instr_o, mq_instr[0]);
    end
    check1("err", err_o, !rst && m_err);
    hold_log.push_back(pc_hold_o);
    vld_log.push_back(id_valid_o);
    err_log.push_back(err_o);
    if (id_valid_o && id_ready_i && !flush_i && !rst) begin
      got_pc.push_back(id_pc_o);
      got_instr.push_back(id_instr_o);
    end
    if (imem_req_valid_o && imem_req_ready_i && !rst) acc_cnt++;
  endtask

  // Model and environment update at the rising edge (pre-edge inputs).
  task automatic update_cycle();
    bit acc;
    bit hold;
    bit idv;
    bit found;
    int back;
    acc  = exp_req_valid() && imem_req_ready_i;
    hold = exp_hold();
    idv  = exp_id_valid();
    if (rst) begin
      mq_pc.delete(); mq_instr.delete(); mq_filled.delete();
      m_drop = 0; m_err = 1'b0;
      inflight.delete();
      spur_req = 1'b0;
      pc_next = RESET_PC;
      return;
    end
    if (flush_i) begin
      back = m_drop;
      foreach (mq_filled[i]) if (!mq_filled[i]) back++;
      if (imem_rsp_valid_i) begin
        if (back > 0) back--;
        else m_err = 1'b1;
      end
      m_drop = back;
      mq_pc.delete(); mq_instr.delete(); mq_filled.delete();
      pc_next = flush_tgt;
    end else begin
      if (idv && id_ready_i) begin
        void'(mq_pc.pop_front());
        void'(mq_instr.pop_front());
        void'(mq_filled.pop_front());
      end
      if (imem_rsp_valid_i) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          found = 1'b0;
          for (int i = 0; i < mq_filled.size(); i++) begin
            if (!found && !mq_filled[i]) begin
              mq_filled[i] = 1'b1;
              mq_instr[i]  = imem_rsp_data_i;
              found = 1'b1;
            end
          end
          if (!found) m_err = 1'b1;
        end
      end
      if (acc) begin
        mq_pc.push_back(pc_i);
        mq_instr.push_back(32'h0);
        mq_filled.push_back(1'b0);
      end
      pc_next = hold ? pc_i : pc_i + 32'd4;
    end
    if (acc) inflight.push_back(pc_i);
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    update_cycle();
    #1;
    pc_i = pc_next;
    if (spur_req) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'hDEAD_BEEF;
      spur_req = 1'b0;
    end else if (rsp_en && inflight.size() > 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = instr_of(inflight.pop_front());
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'h0;
    end
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    flush_i = 1'b0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  int gb, hb, ab, eb;

  initial begin
    rst = 1'b1; pc_i = RESET_PC; flush_i = 1'b0; flush_tgt = 32'h0;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'h0;
    id_ready_i = 1'b0; rsp_en = 1'b1; spur_req = 1'b0;
    m_drop = 0; m_err = 1'b0; acc_cnt = 0; cmp_cnt = 0; bad_cnt = 0;
    pc_next = RESET_PC;

    // Reset values.
    do_reset(3);
    check1("reset_hold", hold_log[0], 1'b1);
    check1("reset_id_valid", vld_log[0], 1'b0);

    // Zero-wait stream.
    imem_req_ready_i = 1'b1; id_ready_i = 1'b1;
    gb = got_pc.size(); hb = hold_log.size();
    repeat (6) step();
    check_got("stream0", gb + 0, 32'h0, 32'h5A5A_0013);
    check_got("stream1", gb + 1, 32'h4, 32'h5A5A_0017);
    check_got("stream2", gb + 2, 32'h8, 32'h5A5A_001B);
    for (int k = 0; k < 6; k++) check1("stream_hold", hold_log[hb + k], 1'b0);
    for (int k = 2; k < 5; k++) check1("stream_valid", vld_log[hb + k], 1'b1);

    // Decode stall: buffer fills to DEPTH then PC freezes at 0x10.
    do_reset(2);
    id_ready_i = 1'b0;
    ab = acc_cnt;
    repeat (10) step();
    check32("stall_accepts", acc_cnt - ab, 32'd4);
    check32("stall_pc", pc_i, 32'h10);
    check1("stall_hold", hold_log[hold_log.size() - 1], 1'b1);
    id_ready_i = 1'b1;
    gb = got_pc.size();
    repeat (8) step();
    check_got("drain0", gb + 0, 32'h0,  32'h5A5A_0013);
    check_got("drain1", gb + 1, 32'h4,  32'h5A5A_0017);
    check_got("drain2", gb + 2, 32'h8,  32'h5A5A_001B);
    check_got("drain3", gb + 3, 32'hC,  32'h5A5A_001F);
    check_got("drain4", gb + 4, 32'h10, 32'h5A5A_0003);

    // Memory not ready: PC held, nothing allocated.
    imem_req_ready_i = 1'b0;
    hb = hold_log.size(); ab = acc_cnt;
    repeat (3) step();
    for (int k = 0; k < 3; k++) check1("noready_hold", hold_log[hb + k], 1'b1);
    check32("noready_accepts", acc_cnt - ab, 32'd0);
    repeat (4) step();

    // Flush with two fetches in flight, no response in the flush cycle.
    flush_i = 1'b1; flush_tgt = 32'h20; step(); flush_i = 1'b0;
    rsp_en = 1'b0; imem_req_ready_i = 1'b1;
    repeat (2) step();
    flush_i = 1'b1; flush_tgt = 32'h100;
    hb = hold_log.size(); gb = got_pc.size();
    step();
    flush_i = 1'b0; rsp_en = 1'b1;
    repeat (8) step();
    check1("flush1_hold", hold_log[hb], 1'b0);
    check_got("flush1_first", gb, 32'h100, 32'h5A5A_0113);

    // Flush coinciding with the response for the older fetch.
    imem_req_ready_i = 1'b0;
    repeat (6) step();
    flush_i = 1'b1; flush_tgt = 32'h20; step(); flush_i = 1'b0;
    rsp_en = 1'b0; imem_req_ready_i = 1'b1;
    step();
    rsp_en = 1'b1;
    step();
    flush_i = 1'b1; flush_tgt = 32'h200;
    hb = hold_log.size(); gb = got_pc.size();
    step();
    flush_i = 1'b0;
    repeat (8) step();
    check1("flush2_hold", hold_log[hb], 1'b0);
    check_got("flush2_first", gb, 32'h200, 32'h5A5A_0213);

    // Spurious response with nothing pending.
    imem_req_ready_i = 1'b0;
    repeat (8) step();
    spur_req = 1'b1;
    step();
    eb = err_log.size();
    step();
    step();
    check1("spur_err_before", err_log[eb], 1'b0);
    check1("spur_err_after", err_log[eb + 1], 1'b1);
    check1("spur_no_valid", vld_log[eb + 1], 1'b0);

    // Asynchronous reset mid-cycle with a valid head and err set.
    id_ready_i = 1'b0; imem_req_ready_i = 1'b1;
    repeat (4) step();
    #1;
    check1("prerst_valid", id_valid_o, 1'b1);
    check1("prerst_err", err_o, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check1("async_rst_err", err_o, 1'b0);
    check1("async_rst_valid", id_valid_o, 1'b0);
    check1("async_rst_hold", pc_hold_o, 1'b1);
    check1("async_rst_req", imem_req_valid_o, 1'b0);
    do_reset(2);

    // Normal operation after reset.
    id_ready_i = 1'b1;
    gb = got_pc.size();
    repeat (6) step();
    check_got("post_rst0", gb, 32'h0, 32'h5A5A_0013);
    check1("post_rst_err", err_log[err_log.size() - 1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule
